// File: rtl/timer_pkg.sv
// Shared types and helpers for the timer subsystem blocks.
package timer_pkg;

    // Top-level countdown FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_t;

    // Prescaler counter width: enough bits for 0..p-1, never narrower than 1.
    function automatic int unsigned presc_width(input int unsigned p);
        int unsigned w;
        w = $clog2(p);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : timer_pkg

// File: rtl/timer_prescaler.sv
// Tick generator for the countdown timer.
// Counts 0..PRESCALE-1 while enabled; tick_o is high in the cycle the counter
// sits at PRESCALE-1, after which it wraps to 0. Holds its value when disabled.
//   clk, rst_n : clock, async active-low reset
//   enable_i   : advance the counter this cycle
//   clear_i    : synchronous clear to 0 (wins over enable)
//   tick_o     : decode of the terminal count while enabled
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned PW = presc_width(PRESCALE);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;
    logic          at_term;

    assign at_term = (cnt_q == PW'(PRESCALE - 1));
    assign tick_o  = enable_i && at_term;

    // Next-count: clear, wrap on tick, advance, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = at_term ? '0 : cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : timer_prescaler

// File: rtl/countdown_timer.sv
// Loadable countdown timer with prescaled decrement, pause/resume and
// optional auto-reload at expiry.
//   clk, resetn : clock, async active-low reset
//   load        : capture load_value into count and reload register
//   load_value  : value captured on load
//   start/stop  : begin/resume and pause pulses
//   reload_en   : at expiry, reload instead of halting
//   count       : remaining count
//   running     : high in RUN
//   expired     : one-cycle pulse at each expiry
//   done        : high in DONE
module countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned PRESCALE   = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_value,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  reload_en,
    output logic [DATA_WIDTH-1:0] count,
    output logic                  running,
    output logic                  expired,
    output logic                  done
);

    timer_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] reload_q, reload_d;
    logic                  expired_q, expired_d;
    logic                  presc_en;
    logic                  tick;

    // load and stop outrank counting, so the prescaler neither advances nor
    // ticks in those cycles; a paused prescaler resumes from where it stopped.
    assign presc_en = (state_q == RUN) && !load && !stop;

    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (resetn),
        .enable_i (presc_en),
        .clear_i  (load),
        .tick_o   (tick)
    );

    // Next-state and datapath: load > stop > start > counting.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        expired_d = 1'b0;
        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            state_d  = IDLE;
        end else if (stop) begin
            if (state_q == RUN) begin
                state_d = PAUSE;
            end
        end else begin
            if (start && (state_q == IDLE || state_q == PAUSE)
                    && (count_q != '0)) begin
                state_d = RUN;
            end
            // tick only fires in RUN, and count is never 0 there
            if (tick) begin
                if (count_q == DATA_WIDTH'(1)) begin
                    expired_d = 1'b1;
                    if (reload_en) begin
                        count_d = reload_q;
                    end else begin
                        count_d = '0;
                        state_d = DONE;
                    end
                end else begin
                    count_d = count_q - DATA_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            expired_q <= expired_d;
        end
    end

    assign count   = count_q;
    assign running = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign expired = expired_q;

endmodule : countdown_timer

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Countdown timer, the downward counterpart of the team's stopwatch block. It is loaded with a start value, decrements at a prescaled rate while running, and flags expiry. It supports pause/resume and optional auto-reload, so it can serve as a periodic tick source. It sits beside the stopwatch in the timer subsystem and is driven by the same start/stop control pulses.

Parameters:
DATA_WIDTH, 16, width of count, load_value and the reload register
PRESCALE, 1, clock cycles per decrement; legal range 1..2^16-1

Ports:
clk  input  1  clock, rising edge
resetn  input  1  asynchronous active-low reset
load  input  1  pulse; capture load_value into count and the reload register
load_value  input  DATA_WIDTH  value captured on load
start  input  1  pulse; begin or resume counting
stop  input  1  pulse; pause counting
reload_en  input  1  level; at expiry, reload count instead of halting
count  output  DATA_WIDTH  current remaining count
running  output  1  high while in RUN
expired  output  1  one-cycle pulse at each expiry
done  output  1  high while in DONE

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (resetn=0) forces immediately:
  - state=IDLE, count=0, reload register=0, prescaler=0
  - running=0, expired=0, done=0
- States:
  - IDLE: loaded, not counting
  - RUN: counting
  - PAUSE: stopped mid-count
  - DONE: expired without reload
- Synchronous priority, highest first: load > stop > start > normal counting.
- load, in any state:
  - count<=load_value, reload register<=load_value, prescaler<=0
  - state<=IDLE; expired=0 that cycle
- start:
  - IDLE or PAUSE with count!=0: state<=RUN.
  - count==0: start is ignored.
  - RUN: no effect.
  - DONE: ignored; only load leaves DONE.
- stop:
  - RUN: state<=PAUSE; prescaler holds its value; resume continues from that value.
  - Other states: no effect.
  - stop and start in the same cycle: stop wins.
- Prescaler in RUN:
  - Counts 0..PRESCALE-1. A tick occurs in the cycle the prescaler is at PRESCALE-1; the prescaler then wraps to 0.
  - With PRESCALE=1, every RUN cycle is a tick.
  - The first decrement occurs PRESCALE cycles after the start edge. Example: PRESCALE=1, count=5, start sampled at edge N -> count=4 after edge N+1.
- Tick with count>1: count<=count-1.
- Tick with count==1 (expiry):
  - expired<=1 for exactly one cycle, coincident with the count update.
  - reload_en=0: count<=0, state<=DONE.
  - reload_en=1: count<=reload register, state stays RUN, prescaler continues seamlessly (period = reload*PRESCALE cycles).
  - reload_en is sampled at the expiry tick only.
- Outputs are registered or decoded from state: running=(state==RUN), done=(state==DONE). No combinational input-to-output path.
- Arithmetic is unsigned; count never underflows, because a tick never happens at count==0 in RUN.
- Reset mid-RUN: all outputs clear asynchronously; counting does not resume after resetn deasserts.

Decomposition:
- Package timer_pkg:
  - state enum timer_state_t {IDLE, RUN, PAUSE, DONE}
  - helper constant for prescaler width: $clog2(PRESCALE) clamped to a minimum of 1
- One natural sub-module: timer_prescaler, the tick generator.
  - Inputs: enable (state==RUN), clear (load).
  - Output: tick.
  - Holds its value while enable=0.
- The top level holds the FSM, count, and reload register.

Test Plan:
- PRESCALE=1: load 3, start, reload_en=0 -> count 2,1,0 on the next three edges; expired pulses with count=0; done=1; running=0; a later start is ignored.
- PRESCALE=3: load 2, start -> count holds 2 for 3 cycles, then 1, then 0 after 3 more cycles (6 cycles total); expired asserted for exactly 1 cycle.
- reload_en=1, PRESCALE=1, load 4, start -> count 3,2,1,4,3,2,1,4...; expired every 4 cycles; running stays 1; done never set.
- Pause/resume, PRESCALE=4: load 10, start, stop after 6 cycles (count=9, prescaler=1) -> holds for 20 cycles; start -> next decrement after 3 cycles.
- Priorities:
  - stop+start together in RUN -> PAUSE.
  - load+stop in RUN -> IDLE with count=load_value.
  - start with count=0 after reset -> stays IDLE.
- Async reset: drop resetn mid-RUN between clock edges -> count=0 and running=0 before the next edge; after release, state is IDLE and count stays 0.
